// File: rtl/rep_id_checker.sv
// rep_id_checker
//   Sequential checker for repeated-digit IDs. An accepted ID is converted to
//   BCD by an iterative double-dabble engine, then tested for being one digit
//   block repeated twice (mode 0) or k >= 2 times (mode 1). A running sum of
//   flagged IDs is kept per stream and reported with the stream's last ID.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  ID handshake; in_ready is high only while idle
//   in_id           unsigned ID
//   in_mode         0 = repeated exactly twice, 1 = repeated k >= 2 times
//   in_last         last ID of the current stream
//   res_valid       one-cycle pulse qualifying res_invalid / res_digits
//   res_invalid     ID matches the selected repetition rule
//   res_digits      decimal digit count of the ID
//   sum_valid       one-cycle pulse with res_valid of the stream's last ID
//   sum_out         stream sum of flagged IDs, including the current one
//   sum_ovf         accumulator wrapped during this stream
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module rep_id_checker #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned MAX_DIGITS = 20,
  parameter int unsigned ACC_WIDTH  = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_id,
  input  logic                  in_mode,
  input  logic                  in_last,
  output logic                  res_valid,
  output logic                  res_invalid,
  output logic [4:0]            res_digits,
  output logic                  sum_valid,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic                  sum_ovf
);

  localparam int unsigned BCD_W = 4 * MAX_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned ACC1  = ACC_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_CHECK, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_id, r_shift;
  logic                  r_mode, r_last, r_flag, r_ovf;
  logic [BCD_W-1:0]      r_bcd, w_bcd_adj, w_mask, w_diff;
  logic [CNT_W-1:0]      r_cnt;
  logic [4:0]            r_digits, r_p, w_ndig, w_p, w_np, w_half;
  logic [ACC_WIDTH-1:0]  r_acc, w_sum;
  logic                  w_carry, w_cnt_done, w_periodic, w_hit, w_last_p, w_flag0;

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Digit count from the highest nonzero nibble; zero counts as one digit.
  always_comb begin
    w_ndig = 5'd1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_ndig = 5'(i + 1);
    end
  end

  // Period test: the BCD string shifted down by p digits must equal its own
  // low n-p digits. Mode 0 is the same test with p = n/2 plus n even.
  always_comb begin
    w_half     = r_digits >> 1;
    w_p        = r_mode ? r_p : w_half;
    w_np       = r_digits - w_p;
    w_mask     = ~({BCD_W{1'b1}} << {w_np, 2'b00});
    w_diff     = ((r_bcd >> {w_p, 2'b00}) ^ r_bcd) & w_mask;
    w_periodic = (w_diff == '0);
    w_flag0    = ~r_digits[0] & w_periodic;
    w_hit      = ((r_digits % r_p) == 5'd0) && (r_p < r_digits) && w_periodic;
    w_last_p   = (r_p >= w_half);
    w_cnt_done = (r_cnt == CNT_W'(DATA_WIDTH));
    {w_carry, w_sum} = {1'b0, r_acc} + ACC1'(r_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    res_invalid  = 1'b0;
    res_digits   = '0;
    sum_valid    = 1'b0;
    sum_out      = r_acc;
    sum_ovf      = r_ovf;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_CONVERT;
      end
      S_CONVERT: if (w_cnt_done) w_state_next = S_CHECK;
      S_CHECK: if (!r_mode || w_hit || w_last_p) w_state_next = S_DONE;
      S_DONE: begin
        res_valid    = 1'b1;
        res_invalid  = r_flag;
        res_digits   = r_digits;
        sum_valid    = r_last;
        sum_out      = r_flag ? w_sum : r_acc;
        sum_ovf      = r_ovf | (r_flag & w_carry);
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id     <= '0;
      r_shift  <= '0;
      r_mode   <= 1'b0;
      r_last   <= 1'b0;
      r_flag   <= 1'b0;
      r_ovf    <= 1'b0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
      r_p      <= 5'd1;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_id    <= in_id;
            r_shift <= in_id;
            r_mode  <= in_mode;
            r_last  <= in_last;
            r_flag  <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CONVERT: begin
          // DATA_WIDTH shift edges, then one closing edge that registers the
          // digit count from the settled BCD value.
          if (w_cnt_done) begin
            r_digits <= w_ndig;
            r_p      <= 5'd1;
          end else begin
            r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[DATA_WIDTH-1]};
            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_flag <= r_mode ? w_hit : w_flag0;
          r_p    <= r_p + 5'd1;
        end
        S_DONE: begin
          if (r_last) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (r_flag) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
